// File: rtl/ram_burst_sequencer.sv
// Burst front-end for the small synchronous RAM: turns valid/ready burst requests into
// per-beat RAM strobes with address auto-increment/wrap and a registered read beat.
module ram_burst_sequencer #(
  parameter int unsigned ADDR_SIZE = 2,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned LEN_SIZE  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [LEN_SIZE-1:0]  req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_we,
  output logic                 ram_rd,
  output logic                 ram_cs,
  output logic [DATA_SIZE-1:0] ram_din,
  input  logic [DATA_SIZE-1:0] ram_dout
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_SIZE-1:0]  remaining_q, remaining_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 done_q, done_d;

  logic wr_beat, rd_issue, beat;

  // Reset gates every handshake and strobe so nothing reaches the RAM while it clears.
  assign wr_beat  = !reset && (state_q == StWrite) && wr_valid;
  assign rd_issue = !reset && (state_q == StRead) && (!rd_valid_q || rd_ready);
  assign beat     = wr_beat || rd_issue;

  assign req_ready = !reset && (state_q == StIdle);
  assign wr_ready  = !reset && (state_q == StWrite);
  assign ram_we    = wr_beat;
  assign ram_rd    = rd_issue;
  assign ram_cs    = beat;
  assign ram_addr  = cur_addr_q;
  assign ram_din   = wr_data;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          cur_addr_d  = req_addr;
          remaining_d = req_len;
          state_d     = req_write ? StWrite : StRead;
        end
      end
      StWrite, StRead: begin
        if (beat) begin
          cur_addr_d  = cur_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The holding register drains in any state, including after the burst has ended.
    if (rd_issue) begin
      rd_valid_d = 1'b1;
      rd_data_d  = ram_dout;
    end else if (rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule

// File: doc/ram_burst_sequencer.md
Name: ram_burst_sequencer

Overview:
Front-end controller that sits directly upstream of the team's small synchronous RAM. It accepts burst read/write requests over a valid/ready handshake and drives the RAM control pins: addr, write enable, read enable and chip select. It streams write beats in and read beats out, each over its own valid/ready handshake. It turns single-word RAM strobes into multi-beat, backpressure-safe transfers with address auto-increment and wrap.

Parameters:
ADDR_SIZE, 2, RAM address width; address space 2^ADDR_SIZE words
DATA_SIZE, 8, RAM word width
LEN_SIZE, 3, width of burst length field; beats per burst = req_len+1 (1..2^LEN_SIZE)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write burst, 0 = read burst
req_addr  in  ADDR_SIZE  start address
req_len  in  LEN_SIZE  beats minus one
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accepted
wr_data  in  DATA_SIZE  write beat data
rd_valid  out  1  read beat valid (registered)
rd_ready  in  1  read beat consumed
rd_data  out  DATA_SIZE  read beat data (registered)
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion
ram_addr  out  ADDR_SIZE  to RAM addr
ram_we  out  1  to RAM WE
ram_rd  out  1  to RAM RD
ram_cs  out  1  to RAM CS
ram_din  out  DATA_SIZE  to RAM dataIn
ram_dout  in  DATA_SIZE  from RAM dataOut (combinational read)

Behaviour:
- Clock clk; reset is synchronous, active-high. The reset line is shared with the RAM, so reset also zeroes memory.
- FSM states: IDLE, WRITE, READ. busy = (state != IDLE).
- Reset: state=IDLE, rd_valid=0, rd_data=0, done=0, address and beat counters=0.
- While reset is high, req_ready, wr_ready, ram_we, ram_rd and ram_cs are forced 0.
- IDLE: req_ready=1. On accept, latch req_addr into cur_addr and req_len into remaining. Next state is WRITE if req_write=1, else READ.
- WRITE:
  - wr_ready=1; ram_din=wr_data (pass-through); ram_addr=cur_addr.
  - A beat occurs on a cycle with wr_valid=1. During a beat, ram_cs=ram_we=1 combinationally, and the RAM captures the word on that clock edge.
  - When wr_valid=0, ram_cs=ram_we=0 and no state changes.
- READ:
  - Issue condition: (!rd_valid || rd_ready).
  - When issuing, ram_cs=ram_rd=1 and ram_addr=cur_addr. At the edge, rd_data<=ram_dout and rd_valid<=1.
  - Otherwise ram_cs=ram_rd=0. If rd_ready=1 at that edge, rd_valid<=0.
  - Latency is 1 cycle from issue to rd_valid. Throughput is 1 beat/cycle while rd_ready=1.
  - rd_data is stable while rd_valid && !rd_ready.
- Every beat:
  - cur_addr <= cur_addr+1 modulo 2^ADDR_SIZE (e.g. 3 -> 0 for ADDR_SIZE=2).
  - remaining <= remaining-1.
  - A beat with remaining==0 is the last beat: next state IDLE, and done<=1 (high for exactly the first IDLE cycle).
- In the done cycle, req_ready=1, so a new request may be accepted the same cycle. No bubble is required beyond the single accept cycle.
- The final read beat may still sit in rd_valid after return to IDLE. It is held until rd_ready. A new read burst does not issue until the holding register frees.
- In IDLE, ram_cs=ram_we=ram_rd=0. wr_ready=0 outside WRITE. wr_valid outside WRITE is ignored.
- A read burst issued after a write burst to the same address returns the written data, because the write commits on the edge of the beat.
- Reset mid-burst aborts the burst:
  - No further RAM strobes.
  - rd_valid drops the cycle after reset is sampled.
  - done is not pulsed.
  - req_ready=1 on the first cycle after reset deasserts.
- req_* inputs are ignored outside IDLE. req_len=0 means a single-beat burst.

Test Plan:
- Reset, then write addr=1 len=2 with wr_data 0xA1,0xB2,0xC3 and wr_valid held high -> ram_we high 3 cycles at ram_addr 1,2,3; done high 1 cycle after the 3rd beat; busy high exactly 3 cycles.
- Read addr=1 len=2 with rd_ready=1 -> rd_data 0xA1,0xB2,0xC3 on 3 consecutive cycles, first one cycle after the first ram_rd; done after the last capture.
- Wrap: write addr=3 len=1 data 0x55,0x66, then read addr=3 len=1 -> ram_addr sequence 3,0; read returns 0x55,0x66.
- Backpressure: read addr=0 len=3, rd_ready low for 3 cycles after the first rd_valid -> rd_data held at mem[0], ram_rd=0 during the stall; all 4 beats arrive in order with none lost or duplicated.
- Write stall: write len=3 with wr_valid pattern 1,0,0,1,1,0,1 -> ram_we asserted only on valid cycles; 4 words land at consecutive addresses; done after the 7th cycle.
- Reset during beat 2 of a 4-beat write -> strobes stop at the next edge, no done, busy=0; the RAM reads back all zero; a new request is accepted in the first post-reset cycle.
